// File: rtl/dmem_arbiter_if.sv
// Purpose : bundle of the two requester ports and the data-memory command/return path.
// Latency : n/a (wires only).
// Backpressure: requesters hold their request until the grant pulse; no other stall.
//
// Ports (by modport):
//   slave  - arbiter view: samples requests and memory read data, drives grants,
//            read-valid pulses, shared read data and the memory command.
//   master - requester/memory view: the mirror image of slave.
interface dmem_arbiter_if #(
  parameter int DW = 32,
  parameter int AW = 32
);
  logic          i_req0;
  logic          i_req1;
  logic          i_wen0;
  logic          i_wen1;
  logic [AW-1:0] i_addr0;
  logic [AW-1:0] i_addr1;
  logic [DW-1:0] i_wdata0;
  logic [DW-1:0] i_wdata1;
  logic          o_gnt0;
  logic          o_gnt1;
  logic          o_rvalid0;
  logic          o_rvalid1;
  logic [DW-1:0] o_rdata;
  logic          o_m_wen;
  logic [AW-1:0] o_m_addr;
  logic [DW-1:0] o_m_wdata;
  logic [DW-1:0] i_m_rdata;

  modport slave (
    input  i_req0, i_req1, i_wen0, i_wen1, i_addr0, i_addr1, i_wdata0, i_wdata1,
    input  i_m_rdata,
    output o_gnt0, o_gnt1, o_rvalid0, o_rvalid1, o_rdata,
    output o_m_wen, o_m_addr, o_m_wdata
  );

  modport master (
    output i_req0, i_req1, i_wen0, i_wen1, i_addr0, i_addr1, i_wdata0, i_wdata1,
    output i_m_rdata,
    input  o_gnt0, o_gnt1, o_rvalid0, o_rvalid1, o_rdata,
    input  o_m_wen, o_m_addr, o_m_wdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Purpose : round-robin arbiter sharing one single-port data memory between core (port 0) and aux loader (port 1).
// Latency : request sampled in IDLE at T, grant + memory command at T+1, read-valid at T+2.
// Backpressure: one access per two cycles; a requester holds req/wen/addr/wdata until it sees its grant.
//
// Ports:
//   i_clk   - single clock, all state on the rising edge.
//   i_rst_n - synchronous active-low reset.
//   bus     - dmem_arbiter_if.slave: requests, grants, read-valid pulses,
//             shared read data (straight from memory) and registered memory command.
module dmem_arbiter #(
  parameter int DW = 32,
  parameter int AW = 32
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  dmem_arbiter_if.slave  bus
);

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_t;

  state_t        state;
  logic          last_gnt1;   // 1 when port 1 won the most recent grant
  logic          pick1;
  logic          gnt0;
  logic          gnt1;
  logic          rvalid0;
  logic          rvalid1;
  logic          m_wen;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;

  // Port 1 wins when it is alone, or when both ask and port 0 was served last.
  always_comb begin
    pick1 = bus.i_req1 & (~bus.i_req0 | ~last_gnt1);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state     <= IDLE;
      last_gnt1 <= 1'b1;      // port 0 has priority out of reset
      gnt0      <= 1'b0;
      gnt1      <= 1'b0;
      rvalid0   <= 1'b0;
      rvalid1   <= 1'b0;
      m_wen     <= 1'b0;
      m_addr    <= '0;
      m_wdata   <= '0;
    end else begin
      // Grants, read-valids and the write strobe are single-cycle pulses;
      // address and write data hold their last value.
      gnt0    <= 1'b0;
      gnt1    <= 1'b0;
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      m_wen   <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.i_req0 || bus.i_req1) begin
            state     <= ISSUE;
            last_gnt1 <= pick1;
            gnt0      <= ~pick1;
            gnt1      <= pick1;
            m_wen     <= pick1 ? bus.i_wen1   : bus.i_wen0;
            m_addr    <= pick1 ? bus.i_addr1  : bus.i_addr0;
            m_wdata   <= pick1 ? bus.i_wdata1 : bus.i_wdata0;
          end
        end
        ISSUE: begin
          // Memory returns data one cycle after the address, so the read-valid
          // lands in the IDLE cycle that follows; writes produce none.
          rvalid0 <= gnt0 & ~m_wen;
          rvalid1 <= gnt1 & ~m_wen;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.o_gnt0    = gnt0;
  assign bus.o_gnt1    = gnt1;
  assign bus.o_rvalid0 = rvalid0;
  assign bus.o_rvalid1 = rvalid1;
  assign bus.o_m_wen   = m_wen;
  assign bus.o_m_addr  = m_addr;
  assign bus.o_m_wdata = m_wdata;
  assign bus.o_rdata   = bus.i_m_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Purpose : directed self-checking bench for dmem_arbiter with a one-cycle-latency memory model.
// Latency : outputs are sampled 1 time unit after each rising edge.
// Backpressure: requests are dropped in the grant cycle unless a step deliberately holds them.
module tb_dmem_arbiter;

  localparam int DW = 32;
  localparam int AW = 32;

  logic i_clk;
  logic i_rst_n;
  int   n_vec;
  int   n_miss;
  int   slot;
  int   cnt0;
  int   cnt1;

  logic [DW-1:0] mem [0:255];

  dmem_arbiter_if #(.DW(DW), .AW(AW)) bus ();

  dmem_arbiter #(.DW(DW), .AW(AW)) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .bus     (bus.slave)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Single-port memory: write on the command cycle, read data one cycle later.
  always @(posedge i_clk) begin
    if (bus.o_m_wen) mem[bus.o_m_addr[7:0]] <= bus.o_m_wdata;
    bus.i_m_rdata <= mem[bus.o_m_addr[7:0]];
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    n_vec  = 0;
    n_miss = 0;
    bus.i_req0   = 1'b0;  bus.i_req1   = 1'b0;
    bus.i_wen0   = 1'b0;  bus.i_wen1   = 1'b0;
    bus.i_addr0  = '0;    bus.i_addr1  = '0;
    bus.i_wdata0 = '0;    bus.i_wdata1 = '0;

    // Reset with both requests asserted: they must be ignored.
    i_rst_n = 1'b0;
    bus.i_req0 = 1'b1; bus.i_req1 = 1'b1;
    tick(); tick(); tick();
    chk("rst_gnt0",    64'(bus.o_gnt0),    64'd0);
    chk("rst_gnt1",    64'(bus.o_gnt1),    64'd0);
    chk("rst_rvalid0", 64'(bus.o_rvalid0), 64'd0);
    chk("rst_rvalid1", 64'(bus.o_rvalid1), 64'd0);
    chk("rst_m_wen",   64'(bus.o_m_wen),   64'd0);
    chk("rst_m_addr",  64'(bus.o_m_addr),  64'd0);
    chk("rst_m_wdata", 64'(bus.o_m_wdata), 64'd0);
    bus.i_req0 = 1'b0; bus.i_req1 = 1'b0;
    i_rst_n = 1'b1;
    tick();
    chk("idle_no_gnt", 64'(bus.o_gnt0 | bus.o_gnt1), 64'd0);

    // Port-0 write 0xDEADBEEF to 0x10.
    bus.i_req0 = 1'b1; bus.i_wen0 = 1'b1; bus.i_addr0 = 32'h10; bus.i_wdata0 = 32'hDEADBEEF;
    tick();
    chk("wr_gnt0",    64'(bus.o_gnt0),    64'd1);
    chk("wr_gnt1",    64'(bus.o_gnt1),    64'd0);
    chk("wr_m_wen",   64'(bus.o_m_wen),   64'd1);
    chk("wr_m_addr",  64'(bus.o_m_addr),  64'h10);
    chk("wr_m_wdata", 64'(bus.o_m_wdata), 64'hDEADBEEF);
    bus.i_req0 = 1'b0;
    tick();
    chk("wr_no_rvalid", 64'(bus.o_rvalid0), 64'd0);
    chk("wr_wen_drop",  64'(bus.o_m_wen),   64'd0);
    chk("wr_gnt_drop",  64'(bus.o_gnt0),    64'd0);

    // Port-0 read back of 0x10.
    bus.i_req0 = 1'b1; bus.i_wen0 = 1'b0; bus.i_addr0 = 32'h10;
    tick();
    chk("rd_gnt0",  64'(bus.o_gnt0),  64'd1);
    chk("rd_m_wen", 64'(bus.o_m_wen), 64'd0);
    bus.i_req0 = 1'b0;
    tick();
    chk("rd_rvalid0",  64'(bus.o_rvalid0), 64'd1);
    chk("rd_rvalid1",  64'(bus.o_rvalid1), 64'd0);
    chk("rd_rdata",    64'(bus.o_rdata),   64'hDEADBEEF);
    chk("rd_gnt_drop", 64'(bus.o_gnt0),    64'd0);

    // Both ports requesting continuously from reset: 8 grants alternate 0,1,...
    i_rst_n = 1'b0;
    bus.i_req0 = 1'b1; bus.i_wen0 = 1'b1; bus.i_addr0 = 32'h20; bus.i_wdata0 = 32'h2020;
    bus.i_req1 = 1'b1; bus.i_wen1 = 1'b1; bus.i_addr1 = 32'h24; bus.i_wdata1 = 32'h2424;
    tick();
    i_rst_n = 1'b1;
    slot = 0; cnt0 = 0; cnt1 = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (bus.o_gnt0 || bus.o_gnt1) begin
        chk("rr_slot_gnt1", 64'(bus.o_gnt1), 64'(slot % 2));
        chk("rr_one_hot",   64'(bus.o_gnt0 & bus.o_gnt1), 64'd0);
        if (bus.o_gnt0) cnt0++;
        if (bus.o_gnt1) cnt1++;
        slot++;
      end
    end
    bus.i_req0 = 1'b0; bus.i_req1 = 1'b0;
    chk("rr_slots", 64'(slot), 64'd8);
    chk("rr_cnt0",  64'(cnt0), 64'd4);
    chk("rr_cnt1",  64'(cnt1), 64'd4);
    tick();

    // Port 1 was granted last: both request, port 0 first, then port 1.
    bus.i_req0 = 1'b1; bus.i_wen0 = 1'b1; bus.i_addr0 = 32'h4; bus.i_wdata0 = 32'h44444444;
    bus.i_req1 = 1'b1; bus.i_wen1 = 1'b1; bus.i_addr1 = 32'h8; bus.i_wdata1 = 32'h88888888;
    tick();
    chk("p1last_gnt0",   64'(bus.o_gnt0),   64'd1);
    chk("p1last_gnt1",   64'(bus.o_gnt1),   64'd0);
    chk("p1last_m_addr", 64'(bus.o_m_addr), 64'h4);
    bus.i_req0 = 1'b0;
    tick();
    chk("p1last_idle", 64'(bus.o_gnt0 | bus.o_gnt1), 64'd0);
    tick();
    chk("p1next_gnt1",    64'(bus.o_gnt1),    64'd1);
    chk("p1next_m_addr",  64'(bus.o_m_addr),  64'h8);
    chk("p1next_m_wdata", 64'(bus.o_m_wdata), 64'h88888888);
    bus.i_req1 = 1'b0;
    tick();

    // Port 0 read granted, then reset lands in its ISSUE cycle.
    bus.i_req0 = 1'b1; bus.i_wen0 = 1'b0; bus.i_addr0 = 32'h10;
    tick();
    chk("abort_gnt0", 64'(bus.o_gnt0), 64'd1);
    bus.i_req0 = 1'b0;
    i_rst_n = 1'b0;
    tick();
    chk("abort_rvalid0", 64'(bus.o_rvalid0), 64'd0);
    chk("abort_m_wen",   64'(bus.o_m_wen),   64'd0);
    chk("abort_gnt0_lo", 64'(bus.o_gnt0),    64'd0);
    // Port 0 won last, so only a reset pointer hands the next tie to port 0;
    // the grant on the very next edge also shows the FSM restarted in IDLE.
    i_rst_n = 1'b1;
    bus.i_req0 = 1'b1; bus.i_wen0 = 1'b1; bus.i_addr0 = 32'h30; bus.i_wdata0 = 32'h3030;
    bus.i_req1 = 1'b1; bus.i_wen1 = 1'b1; bus.i_addr1 = 32'h34; bus.i_wdata1 = 32'h3434;
    tick();
    chk("post_abort_gnt0", 64'(bus.o_gnt0),    64'd1);
    chk("post_abort_gnt1", 64'(bus.o_gnt1),    64'd0);
    chk("post_abort_rv0",  64'(bus.o_rvalid0), 64'd0);
    bus.i_req0 = 1'b0; bus.i_req1 = 1'b0;
    tick();

    // Back-to-back port-0 reads of 0x4 then 0x8 with req held high: the second
    // request is taken in the same IDLE cycle that carries the first read-valid.
    bus.i_req0 = 1'b1; bus.i_wen0 = 1'b0; bus.i_addr0 = 32'h4;
    tick();
    chk("b2b_gnt_a", 64'(bus.o_gnt0), 64'd1);
    bus.i_addr0 = 32'h8;
    tick();
    chk("b2b_rvalid_a", 64'(bus.o_rvalid0), 64'd1);
    chk("b2b_rdata_a",  64'(bus.o_rdata),   64'h44444444);
    chk("b2b_gap",      64'(bus.o_gnt0),    64'd0);
    tick();
    chk("b2b_gnt_b",    64'(bus.o_gnt0),    64'd1);
    chk("b2b_m_addr_b", 64'(bus.o_m_addr),  64'h8);
    chk("b2b_rv_gap",   64'(bus.o_rvalid0), 64'd0);
    bus.i_req0 = 1'b0;
    tick();
    chk("b2b_rvalid_b", 64'(bus.o_rvalid0), 64'd1);
    chk("b2b_rdata_b",  64'(bus.o_rdata),   64'h88888888);
    chk("b2b_rv1_lo",   64'(bus.o_rvalid1), 64'd0);
    tick();
    chk("b2b_rv_end",   64'(bus.o_rvalid0), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
